// File: rtl/mult_digit_serial_pkg.sv
// mult_digit_serial_pkg: shared state type and sizing helpers for the digit-serial multiplier
package mult_digit_serial_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  localparam int DEF_BITS = 258;
  localparam int DEF_DIGIT = 16;
  function automatic int num_digits(input int bits, input int digit);
    return (bits + digit - 1) / digit;
  endfunction
  function automatic int cnt_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_CNT_BITS = cnt_bits(num_digits(DEF_BITS, DEF_DIGIT));
endpackage

// File: rtl/mult_digit_pp.sv
// mult_digit_pp: combinational BITS x DIGIT unsigned partial product
module mult_digit_pp #(
  parameter int BITS = 258,
  parameter int DIGIT = 16
) (
  input  logic [BITS-1:0]       a,
  input  logic [DIGIT-1:0]      d,
  output logic [BITS+DIGIT-1:0] p
);
  assign p = (BITS+DIGIT)'(a) * (BITS+DIGIT)'(d);
endmodule

// File: rtl/mult_digit_serial.sv
// mult_digit_serial: digit-serial a*b stream multiplier; MULT_DIGIT_SERIAL_EARLY_EXIT_EN stops after b's top non-zero digit
module mult_digit_serial
  import mult_digit_serial_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int DIGIT = DEF_DIGIT,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mult_val,
  output logic                i_mult_rdy,
  input  logic [2*BITS-1:0]   i_mult_dat,
  input  logic                i_mult_sop,
  input  logic                i_mult_eop,
  input  logic                i_mult_err,
  input  logic [MOD_BITS-1:0] i_mult_mod,
  input  logic [CTL_BITS-1:0] i_mult_ctl,
  output logic                o_mult_val,
  input  logic                o_mult_rdy,
  output logic [2*BITS-1:0]   o_mult_dat,
  output logic                o_mult_sop,
  output logic                o_mult_eop,
  output logic                o_mult_err,
  output logic [MOD_BITS-1:0] o_mult_mod,
  output logic [CTL_BITS-1:0] o_mult_ctl
);
  localparam int N = num_digits(BITS, DIGIT);
  localparam int NB = N * DIGIT;
  localparam int PW = 2 * BITS;
  localparam int CW = cnt_bits(N);
  state_t state;
  logic [BITS-1:0] a;
  logic [NB-1:0] b, b_in;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt, last, last_in;
  logic fin;
  logic [BITS+DIGIT-1:0] pp;
  assign b_in = NB'(i_mult_dat[BITS +: BITS]);
`ifdef MULT_DIGIT_SERIAL_EARLY_EXIT_EN
  always_comb begin
    last_in = '0;
    for (int d = 0; d < N; d++) if (b_in[d*DIGIT +: DIGIT] != '0) last_in = CW'(d);
  end
`else
  assign last_in = CW'(N - 1);
`endif
  mult_digit_pp #(.BITS(BITS), .DIGIT(DIGIT)) u_pp (.a(a), .d(b[DIGIT-1:0]), .p(pp));
  // b shifts right so the current digit always sits at the bottom; acc is exact in 2*BITS since a,b < 2^BITS
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      i_mult_rdy <= 1'b0;
      o_mult_val <= 1'b0;
      o_mult_dat <= '0;
      o_mult_sop <= 1'b0;
      o_mult_eop <= 1'b0;
      o_mult_err <= 1'b0;
      o_mult_mod <= '0;
      o_mult_ctl <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
      last <= '0;
      fin <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_mult_rdy <= 1'b1;
          if (i_mult_val && i_mult_rdy) begin
            a <= i_mult_dat[BITS-1:0];
            b <= b_in;
            last <= last_in;
            o_mult_sop <= i_mult_sop;
            o_mult_eop <= i_mult_eop;
            o_mult_err <= i_mult_err;
            o_mult_mod <= i_mult_mod;
            o_mult_ctl <= i_mult_ctl;
            acc <= '0;
            cnt <= '0;
            fin <= 1'b0;
            i_mult_rdy <= 1'b0;
            state <= MULT;
          end
        end
        MULT: begin
          if (!fin) begin
            acc <= acc + (PW'(pp) << (int'(cnt) * DIGIT));
            b <= b >> DIGIT;
            cnt <= cnt + CW'(1);
            fin <= cnt == last;
          end else begin
            o_mult_dat <= acc;
            o_mult_val <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (o_mult_rdy) begin
            o_mult_val <= 1'b0;
            i_mult_rdy <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
